// File: rtl/ram_copier.sv
// ram_copier
// ----------
// Block-copy initiator for a zero-delay, single-channel RAM with a shared
// tri-state data bus. A start command latches a source address, a destination
// address and a word count. The block then alternates READ and WRITE cycles,
// one word per two cycles, and raises a one-cycle done pulse in FINISH.
//
// Ports:
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   start        copy request, sampled only in IDLE
//   source       first source word address, sampled with start
//   destination  first destination word address, sampled with start
//   length       number of words to copy (0 .. 2**ADDRESS_BITS), sampled with start
//   busy         high while a copy is in progress (READ/WRITE)
//   done         one-cycle pulse when a copy completes
//   ram_write    RAM write pin, high only in WRITE
//   ram_address  RAM address pin
//   ram_data     shared RAM data bus, driven here only while ram_write=1

module ram_copier #(
    parameter int ADDRESS_BITS = 1,
    parameter int DATA_BITS    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] source,
    input  logic [ADDRESS_BITS-1:0] destination,
    input  logic [ADDRESS_BITS:0]   length,
    output logic                    busy,
    output logic                    done,
    output logic                    ram_write,
    output logic [ADDRESS_BITS-1:0] ram_address,
    inout  wire  [DATA_BITS-1:0]    ram_data
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FINISH
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDRESS_BITS-1:0] src_ptr;
    logic [ADDRESS_BITS-1:0] dst_ptr;
    logic [ADDRESS_BITS:0]   remaining;
    logic [DATA_BITS-1:0]    buffer;

    // State register plus the copy datapath. Operands are latched when a
    // request is taken in IDLE. The word on the bus is captured at the end of
    // READ, because the RAM drives it combinationally from ram_address. Both
    // pointers advance after each WRITE and wrap naturally at the top of the
    // address space.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            buffer    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= source;
                        dst_ptr   <= destination;
                        remaining <= length;
                    end
                end
                READ: begin
                    buffer <= ram_data;
                end
                WRITE: begin
                    src_ptr   <= src_ptr + ADDRESS_BITS'(1);
                    dst_ptr   <= dst_ptr + ADDRESS_BITS'(1);
                    remaining <= remaining - (ADDRESS_BITS + 1)'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode. All outputs are functions of the state
    // alone, so busy and done can never be high together. A request with a
    // zero length skips straight to FINISH so that it still produces a done
    // pulse. In WRITE, the count still holds its pre-decrement value, so a
    // value of one marks the last word.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        ram_write   = 1'b0;
        ram_address = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? FINISH : READ;
                end
            end
            READ: begin
                busy        = 1'b1;
                ram_address = src_ptr;
                state_next  = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                ram_write   = 1'b1;
                ram_address = dst_ptr;
                state_next  = (remaining == (ADDRESS_BITS + 1)'(1)) ? FINISH : READ;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The bus is released whenever this block is not writing, so the RAM can
    // drive it without contention.
    assign ram_data = ram_write ? buffer : {DATA_BITS{1'bz}};

endmodule

// File: tb/tb_ram_copier.sv
// tb_ram_copier
// -------------
// Self-checking bench for ram_copier with ADDRESS_BITS=4 and DATA_BITS=8.
// It contains a behavioural RAM that drives the bus whenever ram_write is low.
// A reference memory is updated word by word from the copy rules. The bench
// runs a table of directed copies, a set of random copies and hand-written
// sequences: start while busy, start held through FINISH, and reset mid-copy.

module tb_ram_copier;

    localparam int DEPTH = 16;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] source;
    logic [3:0] destination;
    logic [4:0] length;
    logic       busy;
    logic       done;
    logic       ram_write;
    logic [3:0] ram_address;
    wire  [7:0] ram_data;

    logic [7:0] mem       [DEPTH];
    logic [7:0] loadImage [DEPTH];
    logic [7:0] refMem    [DEPTH];
    logic       loadReq;
    logic       monOn;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] src;
        logic [3:0] dst;
        logic [4:0] len;
        int         expLat;
        int         expBusy;
    } vec_t;

    vec_t vecs [6];

    ram_copier #(
        .ADDRESS_BITS(4),
        .DATA_BITS   (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .source     (source),
        .destination(destination),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .ram_write  (ram_write),
        .ram_address(ram_address),
        .ram_data   (ram_data)
    );

    // Clock generation, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Zero-delay RAM. It reads combinationally whenever the copier is not
    // writing. Writes and image loads take effect on the rising edge.
    assign ram_data = ram_write ? 8'bz : mem[ram_address];

    always @(posedge clock) begin
        if (loadReq)
            mem <= loadImage;
        else if (ram_write)
            mem[ram_address] <= ram_data;
    end

    // Per-cycle bus and output sanity checks. While the copier is not writing,
    // the bus must carry exactly the RAM's word; any copier drive would corrupt
    // it. While the copier is writing, the bus must be fully known.
    always @(negedge clock) begin
        if (monOn) begin
            total++;
            if ((busy && done) || (ram_write && !busy) ||
                (ram_write ? $isunknown(ram_data) : (ram_data !== mem[ram_address]))) begin
                bad++;
                $display("[TB] FAIL bus: busy=%0b done=%0b write=%0b data=%h ram_word=%h",
                         busy, done, ram_write, ram_data, mem[ram_address]);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    // Reference copy: strictly ascending, word by word, with 4-bit wrap.
    function automatic void modelCopy(input logic [3:0] s, input logic [3:0] d, input int l);
        for (int i = 0; i < l; i++)
            refMem[d + 4'(i)] = refMem[s + 4'(i)];
    endfunction

    function automatic int memErrors();
        int n = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== refMem[i]) n++;
        return n;
    endfunction

    task automatic loadMem();
        @(negedge clock);
        loadReq = 1'b1;
        @(posedge clock);
        #1 loadReq = 1'b0;
        refMem = loadImage;
    endtask

    task automatic fixedImage();
        for (int i = 0; i < DEPTH; i++)
            loadImage[i] = 8'(17 * (i - 1));
    endtask

    // Issue one start, then watch the copy cycle by cycle. The task reports
    // the done latency, the busy cycle count, address/write sequence errors
    // and whether anything stayed high after the done pulse.
    task automatic applyStimulus(input logic [3:0] s, input logic [3:0] d, input logic [4:0] l,
                                 output int lat, output int busyCyc, output int addrErr,
                                 output int doneAfter);
        logic [3:0] ea;
        logic       ew;
        @(negedge clock);
        source      = s;
        destination = d;
        length      = l;
        start       = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat       = -1;
        busyCyc   = 0;
        addrErr   = 0;
        doneAfter = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (busy) begin
                busyCyc++;
                if (k % 2 == 1) begin
                    ea = s + 4'((k - 1) / 2);
                    ew = 1'b0;
                end else begin
                    ea = d + 4'((k - 2) / 2);
                    ew = 1'b1;
                end
                if (ram_address !== ea || ram_write !== ew) addrErr++;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat >= 0) begin
            @(negedge clock);
            doneAfter = (done || busy) ? 1 : 0;
        end
    endtask

    task automatic runAndCheck(input logic [3:0] s, input logic [3:0] d, input logic [4:0] l,
                               input int expLat, input int expBusy);
        int lat, busyCyc, addrErr, doneAfter;
        modelCopy(s, d, int'(l));
        applyStimulus(s, d, l, lat, busyCyc, addrErr, doneAfter);
        checkOutput("latency", lat, expLat);
        checkOutput("busyCycles", busyCyc, expBusy);
        checkOutput("addrSequence", addrErr, 0);
        checkOutput("donePulseWidth", doneAfter, 0);
        checkOutput("memory", memErrors(), 0);
    endtask

    initial begin
        int doneCnt, busyCnt, firstDone, secondDone;

        vecs[0] = '{4'd2,  4'd9,  5'd3,  7,  6};
        vecs[1] = '{4'd5,  4'd6,  5'd0,  1,  0};
        vecs[2] = '{4'd14, 4'd0,  5'd4,  9,  8};
        vecs[3] = '{4'd3,  4'd3,  5'd2,  5,  4};
        vecs[4] = '{4'd7,  4'd12, 5'd16, 33, 32};
        vecs[5] = '{4'd1,  4'd2,  5'd5,  11, 10};

        monOn       = 1'b0;
        loadReq     = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        source      = '0;
        destination = '0;
        length      = '0;

        // Reset state, and start being ignored while reset is held.
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset ram_write", int'(ram_write), 0);
        checkOutput("reset ram_address", int'(ram_address), 0);
        source = 4'd3; destination = 4'd7; length = 5'd3; start = 1'b1;
        @(negedge clock);
        checkOutput("start under reset", int'(busy), 0);
        start = 1'b0;
        reset = 1'b0;

        fixedImage();
        loadMem();
        monOn = 1'b1;

        // Directed copies from the table.
        for (int v = 0; v < 6; v++) begin
            fixedImage();
            loadMem();
            runAndCheck(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].expLat, vecs[v].expBusy);
        end

        // Random copies against the reference model.
        for (int r = 0; r < 20; r++) begin
            logic [3:0] s, d;
            logic [4:0] l;
            for (int i = 0; i < DEPTH; i++)
                loadImage[i] = 8'($urandom);
            loadMem();
            s = 4'($urandom);
            d = 4'($urandom);
            l = 5'($urandom_range(0, 16));
            runAndCheck(s, d, l, 2 * int'(l) + 1, 2 * int'(l));
        end

        // start while busy is ignored; start held through FINISH relaunches
        // from IDLE.
        fixedImage();
        loadMem();
        modelCopy(4'd1, 4'd8, 3);
        modelCopy(4'd6, 4'd13, 2);
        @(negedge clock);
        source = 4'd1; destination = 4'd8; length = 5'd3; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        doneCnt = 0; firstDone = -1; secondDone = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (done) begin
                doneCnt++;
                if (firstDone < 0) firstDone = k;
                else secondDone = k;
            end
            if (k == 8) checkOutput("idle after finish", int'(busy) + int'(done), 0);
            if (k == 9) checkOutput("relaunch busy", int'(busy), 1);
            case (k)
                2, 4: begin
                    source = 4'd0; destination = 4'd12; length = 5'd2; start = 1'b1;
                end
                3, 5: start = 1'b0;
                6: begin
                    source = 4'd6; destination = 4'd13; length = 5'd2; start = 1'b1;
                end
                9: start = 1'b0;
                default: begin
                end
            endcase
        end
        checkOutput("ignored starts done count", doneCnt, 2);
        checkOutput("first done cycle", firstDone, 7);
        checkOutput("second done cycle", secondDone, 13);
        checkOutput("ignored starts memory", memErrors(), 0);

        // Reset during the second WRITE of a length-5 copy.
        fixedImage();
        loadMem();
        @(negedge clock);
        source = 4'd0; destination = 4'd8; length = 5'd5; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("second write", int'(ram_write), 1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort ram_write", int'(ram_write), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort ram_address", int'(ram_address), 0);
        reset = 1'b0;
        doneCnt = 0; busyCnt = 0;
        repeat (6) begin
            @(negedge clock);
            doneCnt += int'(done);
            busyCnt += int'(busy);
        end
        checkOutput("abort no done", doneCnt, 0);
        checkOutput("abort stays idle", busyCnt, 0);
        refMem[8] = loadImage[0];
        refMem[9] = loadImage[1];
        checkOutput("abort memory", memErrors(), 0);

        monOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
